// File: rtl/modulo_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, returning
// either remainder or quotient (unsigned or two's-complement) with N/Z/C/V flags.
module modulo_iter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signo,
    input  logic         modo,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] c,
    output logic [3:0]   banderas
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state;
    logic [n-1:0]  rem, quo, dvsr;
    logic [CW-1:0] cnt;
    logic          neg_a, neg_b, sgn, mod_q, dz, ovf;

    logic [n-1:0]  a_abs, b_abs, q_res, r_res, res;
    logic [n:0]    rem_shift, diff;
    logic          v_flag;

    always_comb begin
        a_abs     = (signo && a[n-1]) ? -a : a;
        b_abs     = (signo && b[n-1]) ? -b : b;
        rem_shift = {rem, quo[n-1]};
        diff      = rem_shift - {1'b0, dvsr};
        q_res     = (sgn && (neg_a ^ neg_b)) ? -quo : quo;
        r_res     = (sgn && neg_a) ? -rem : rem;
        // Divide-by-zero keeps the raw dividend in quo so the remainder is a itself.
        if (dz) res = mod_q ? '1 : quo;
        else    res = mod_q ? q_res : r_res;
        v_flag    = dz | (ovf & mod_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            c        <= '0;
            banderas <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            sgn      <= 1'b0;
            mod_q    <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sgn   <= signo;
                    mod_q <= modo;
                    neg_a <= signo & a[n-1];
                    neg_b <= signo & b[n-1];
                    rem   <= '0;
                    busy  <= 1'b1;
                    if (b != '0) begin
                        quo   <= a_abs;
                        dvsr  <= b_abs;
                        cnt   <= CW'(n - 1);
                        dz    <= 1'b0;
                        ovf   <= signo && (a == {1'b1, {(n-1){1'b0}}}) && (b == '1);
                        state <= CALC;
                    end else begin
                        quo   <= a;
                        dvsr  <= '0;
                        cnt   <= '0;
                        dz    <= 1'b1;
                        ovf   <= 1'b0;
                        state <= FIN;
                    end
                end
                CALC: begin
                    if (!diff[n]) begin
                        rem <= diff[n-1:0];
                        quo <= {quo[n-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[n-1:0];
                        quo <= {quo[n-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIN;
                end
                FIN: begin
                    c        <= res;
                    banderas <= {sgn & res[n-1], res == '0, 1'b0, v_flag};
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modulo_iter.sv
// Directed bench for modulo_iter (n=32): an arithmetic model predicts every
// cycle's busy/done/c/banderas, and literal expectations pin the model.
module tb_modulo_iter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic         signo = 1'b0, modo = 1'b0;
    logic         busy, done;
    logic [N-1:0] c;
    logic [3:0]   banderas;

    int nvec = 0;
    int nerr = 0;

    modulo_iter #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signo(signo), .modo(modo), .busy(busy), .done(done),
        .c(c), .banderas(banderas)
    );

    always #5 clk = ~clk;

    // Result from the arithmetic definition: truncating division on wide ints.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms, input logic mm,
                                  output logic [31:0] rc, output logic [3:0] rf);
        longint sa, sb, q, r;
        logic   v;
        if (mb == 0) begin
            rc = mm ? 32'hFFFF_FFFF : ma;
            v  = 1'b1;
        end else begin
            if (ms) begin
                sa = longint'($signed(ma));
                sb = longint'($signed(mb));
            end else begin
                sa = longint'(ma);
                sb = longint'(mb);
            end
            q  = sa / sb;
            r  = sa % sb;
            rc = mm ? q[31:0] : r[31:0];
            v  = mm && ms && (q > 64'sd2147483647);
        end
        rf = {ms & rc[31], rc == 0, 1'b0, v};
    endfunction

    // Cycle-level expectation: accepted op reports after a fixed number of edges.
    int          pend;
    logic        exp_busy, exp_done;
    logic [31:0] exp_c, pres;
    logic [3:0]  exp_f, pflags;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 0; exp_busy = 0; exp_done = 0; exp_c = 0; exp_f = 0;
        end else begin
            exp_done = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    exp_done = 1; exp_c = pres; exp_f = pflags;
                end
            end else if (start) begin
                model(a, b, signo, modo, pres, pflags);
                pend = (b == 0) ? 1 : N + 1;
            end
            exp_busy = (pend > 0);
        end
    end

    always @(negedge clk) begin
        nvec++;
        if ({busy, done, c, banderas} !== {exp_busy, exp_done, exp_c, exp_f}) begin
            nerr++;
            $display("FAIL cycle t=%0t: got busy=%b done=%b c=%h f=%b, want busy=%b done=%b c=%h f=%b",
                     $time, busy, done, c, banderas, exp_busy, exp_done, exp_c, exp_f);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input string name, input logic [31:0] oa, input logic [31:0] ob,
                         input logic os, input logic om, input logic [31:0] wc,
                         input logic [3:0] wf, input int wlat, input bit poke);
        int k;
        a = oa; b = ob; signo = os; modo = om; start = 1'b1;
        @(negedge clk);
        k = 1;
        start = 1'b0;
        a = ~oa; b = ob ^ 32'h5; signo = ~os; modo = ~om;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            start = (poke && k == 10);
        end
        start = 1'b0;
        check({name, " latency"}, 64'(k), 64'(wlat));
        check({name, " c"}, 64'(c), 64'(wc));
        check({name, " flags"}, 64'(banderas), 64'(wf));
    endtask

    initial begin
        int dcount;
        #12;
        check("reset outputs", {busy, done, banderas, c}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("urem 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 4'b0000, N + 2, 1'b0);
        do_op("uquo 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 4'b0000, N + 2, 1'b1);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no extra done", 64'(dcount), 64'd0);

        do_op("srem -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1000, N + 2, 1'b0);
        do_op("squo -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 4'b1000, N + 2, 1'b0);
        do_op("dz rem", 32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 4'b0001, 2, 1'b0);
        do_op("dz quo s", 32'd5, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1001, 2, 1'b0);
        do_op("dz quo u", 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0001, 2, 1'b0);
        do_op("zero rem", 32'd12, 32'd4, 1'b0, 1'b0, 32'd0, 4'b0100, N + 2, 1'b0);
        do_op("s ovf quo", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 4'b1001, N + 2, 1'b0);
        do_op("s ovf rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 4'b0100, N + 2, 1'b0);
        do_op("squo 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 4'b1000, N + 2, 1'b0);
        do_op("urem big", 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0, 32'd5, 4'b0000, N + 2, 1'b0);
        do_op("squo -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd14, 4'b0000, N + 2, 1'b0);

        // Mid-operation reset: outputs clear without a clock edge, no done follows.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signo = 1'b0; modo = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset", {busy, done, banderas, c}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no done after reset", 64'(dcount), 64'd0);
        do_op("urem 9/4", 32'd9, 32'd4, 1'b0, 1'b0, 32'd1, 4'b0000, N + 2, 1'b0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/modulo_iter.md
MODULO_ITER -- requirements
Module: modulo_iter

Interface
- REQ-001 Parameter n, default 32: operand and result width; legal range 4..64.
- REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
- REQ-003 rst_n  in  1  reset; asynchronous, active-low.
- REQ-004 start  in  1  request; sampled only in IDLE.
- REQ-005 a  in  n  dividend; captured on the accepting edge.
- REQ-006 b  in  n  divisor; captured on the accepting edge.
- REQ-007 signo  in  1  captured with a and b.
  - 1 = two's-complement operands.
  - 0 = unsigned operands.
- REQ-008 modo  in  1  captured with a and b.
  - 0 = c returns the remainder.
  - 1 = c returns the quotient.
- REQ-009 busy  out  1  high while an operation is in progress, in states CALC and FIN.
- REQ-010 done  out  1  single-cycle pulse; c and banderas are valid from this cycle onward.
- REQ-011 c  out  n  result; registered; holds its value until the next done.
- REQ-012 banderas  out  4  registered flags: [3] N, [2] Z, [1] C, [0] V.

Function
- REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, FIN.
- REQ-014 IDLE -> CALC SHALL occur on an edge where start=1 and b!=0.
  - On that edge, capture |a|, |b| (signed mode), both operand signs, signo and modo.
  - Clear the partial remainder and load the bit counter with n-1.
- REQ-015 IDLE -> FIN SHALL occur on an edge where start=1 and b=0 (divide-by-zero path).
- REQ-016 CALC SHALL perform one restoring-division step per cycle, MSB first.
  - Each step: shift the partial remainder left, bringing in the next dividend bit; subtract the divisor; if the result is non-negative, keep it and set the quotient bit, otherwise restore.
  - Exactly n cycles are spent in CALC, then the FSM moves to FIN.
- REQ-017 FIN SHALL register c, banderas and done=1 for one cycle, then return to IDLE.
- REQ-018 Latency: done SHALL be high in the cycle following edge n+1, counting the accepting edge as 0.
  - Normal path: n+2 cycles from the accepting edge to the done cycle.
  - Divide-by-zero path: 2 cycles.
- REQ-019 Signed results SHALL follow truncation toward zero.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- REQ-020 Divide by zero SHALL produce:
  - remainder c = a;
  - quotient c = all ones;
  - banderas[0] = 1.
- REQ-021 Signed overflow (a = most negative value, b = -1) SHALL produce:
  - quotient c = most negative value, banderas[0] = 1;
  - remainder c = 0, banderas[0] = 0.
- REQ-022 banderas[3] SHALL equal c[n-1] when signo=1, and 0 when signo=0.
- REQ-023 banderas[2] SHALL equal (c == 0).
- REQ-024 banderas[1] SHALL always be 0.
- REQ-025 start while busy=1 SHALL be ignored; it is not queued.
- REQ-026 start asserted in the done cycle (state IDLE) SHALL be accepted.
- REQ-027 Changes to a, b, signo or modo after acceptance SHALL NOT affect the operation in progress.

Reset
- REQ-028 rst_n=0 SHALL immediately force:
  - state = IDLE;
  - busy = 0, done = 0;
  - c = 0, banderas = 0;
  - bit counter = 0, internal registers = 0.
- REQ-029 Reset during CALC or FIN SHALL abort the operation with no done pulse.
  - The first start after rst_n returns high SHALL be accepted normally.

Verification (n=32)
- REQ-030 Unsigned remainder: a=100, b=7, signo=0, modo=0.
  - Response: done exactly 34 cycles after the accepting edge; c=2; banderas=0000.
  - busy high for all 33 intervening cycles.
- REQ-031 Unsigned quotient with ignored start: a=100, b=7, modo=1; pulse start again mid-CALC.
  - Response: c=14; exactly one done pulse.
- REQ-032 Signed operands: a=0xFFFFFFF9 (-7), b=2, signo=1.
  - modo=0: c=0xFFFFFFFF, banderas=1000.
  - modo=1: c=0xFFFFFFFD, banderas=1000.
- REQ-033 Divide by zero: a=5, b=0, modo=0 then modo=1.
  - modo=0: done after 2 cycles; c=5, banderas=0001.
  - modo=1: c=0xFFFFFFFF, banderas=1001 (signo=1) or 0001 (signo=0).
- REQ-034 Zero remainder and signed overflow: a=12, b=4, modo=0 -> c=0, banderas=0100; then a=0x80000000, b=0xFFFFFFFF, signo=1, modo=1.
  - Response: c=0x80000000, banderas=1001.
- REQ-035 Reset mid-operation: rst_n low at cycle 10 of CALC.
  - Response: busy, done, c and banderas go to 0 without waiting for a clock edge; no done pulse.
  - A following a=9, b=4 remainder operation returns c=1.
